branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the five-stage RISC-V pipeline. It sits upstream of the pipeline controller, in the IF stage. Each cycle it looks up the fetch PC and produces a taken/not-taken prediction and a target; that prediction bit travels down the pipe as `id_br_pred`/`ex_br_pred`. It learns from branch outcomes resolved in EX, using a direct-mapped table of tagged 2-bit saturating counters and branch targets.

## Interface
Parameters:
- `PC_W`, 32, PC and target width in bits.
- `ENTRIES`, 16, number of table entries; power of two, minimum 2.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `lk_valid` input 1: the fetch-stage lookup is live this cycle; used for statistics only.
- `lk_pc` input PC_W: fetch PC to look up.
- `pred_taken` output 1: predict taken; feeds the pipeline's `br_pred` bit.
- `pred_target` output PC_W: predicted target; 0 when `pred_taken`=0.
- `upd_valid` input 1: a conditional branch (BEQ opcode class) resolved in EX this cycle.
- `upd_pc` input PC_W: PC of the resolved branch.
- `upd_taken` input 1: resolved outcome, i.e. the controller's `br_taken`.
- `upd_target` input PC_W: resolved taken-target.
- `upd_mispred` input 1: the prediction for this branch was wrong; used for statistics only.
- `stat_lookups` output 32: present only with `BP_STATS_EN`.
- `stat_updates` output 32: present only with `BP_STATS_EN`.
- `stat_mispred` output 32: present only with `BP_STATS_EN`.

## Operation
- IDX_W = $clog2(ENTRIES).
- Index = pc[IDX_W+1:2].
- Tag = pc[PC_W-1:IDX_W+2].
- Bits pc[1:0] are ignored.
- Per-entry state:
  - `valid` (1 bit)
  - `tag`
  - `ctr` (2 bits): 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T
  - `target` (PC_W bits)
- Lookup is combinational from registered state:
  - hit = valid[idx] && tag[idx]==lk_tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : 0.
- Update occurs at the clock edge when `upd_valid`=1:
  - Hit (valid, tag equal): ctr increments if `upd_taken`, decrements otherwise, saturating at 11 and 00. If `upd_taken`, target ← upd_target; otherwise target is unchanged.
  - Miss (invalid or tag differs): allocate and replace. valid←1, tag←upd tag, target←upd_target, ctr←`upd_taken` ? 10 : 01.
- `upd_valid`=0: no table change; `upd_*` values are don't-care.
- Same-index lookup and update in one cycle: the lookup returns the pre-update value. There is no bypass.
- Two aliasing PCs (same index, different tag) evict each other. There is no associativity.

## Timing
- Lookup latency is 0 cycles: `pred_*` follow `lk_pc` combinationally.
- An update is visible to lookups from the cycle after `upd_valid`.
- Reset (synchronous, one cycle):
  - all valid←0, all ctr←01, all target←0, all tags←0
  - stat counters←0
  - `pred_taken`=0 and `pred_target`=0 from the cycle after `rst` is sampled high
- Reset asserted together with `upd_valid`: reset wins and the update is discarded.
- Reset in the middle of any sequence clears all learned state.
- Stall and flush are handled by the pipeline registers; this block has no stall input, and a repeated lookup of the same PC is harmless.

## Configuration
- `BP_STATS_EN` defined:
  - Three 32-bit counters are compiled in.
  - `stat_lookups` +1 per cycle with `lk_valid`.
  - `stat_updates` +1 per cycle with `upd_valid`.
  - `stat_mispred` +1 per cycle with `upd_valid && upd_mispred`.
  - Each counter saturates at 32'hFFFF_FFFF and does not wrap.
  - All three clear on `rst`.
- `BP_STATS_EN` undefined: the stat ports and counters do not exist. Prediction behaviour is identical in both builds.

## Test plan
- Reset then lookup: `rst`=1 for one cycle, then `lk_pc`=0x100 → `pred_taken`=0, `pred_target`=0.
- Allocate and train:
  - Update pc 0x100, taken=1, target 0x80 → next cycle lookup 0x100 gives `pred_taken`=1, `pred_target`=0x80 (ctr=10).
  - A second taken update → ctr=11.
  - Two not-taken updates → ctr=01, `pred_taken`=0.
- Saturation:
  - Five taken updates to 0x40 → ctr stays 11.
  - One not-taken update → ctr=10, still predicts taken.
- Alias eviction (ENTRIES=16):
  - 0x100 trained taken; taken update to 0x140 (same index 0, different tag) → lookup 0x140 gives taken with its own target.
  - Lookup 0x100 → `pred_taken`=0 (tag miss).
- Same-cycle and reset conflicts:
  - Lookup 0x100 in the same cycle as a not-taken update at ctr=10 → predicts taken this cycle, not taken the next cycle.
  - `rst` together with `upd_valid` → table stays empty.
- `BP_STATS_EN` build:
  - 10 `lk_valid` cycles, 4 updates (2 with `upd_mispred`) → counts 10/4/2.
  - `rst` → all three read 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-update bundle between the pipeline and the branch predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_predictor_if #(
    parameter int PC_W = 32
);
    logic            lk_valid;
    logic [PC_W-1:0] lk_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_mispred;

    modport master (
        output lk_valid, lk_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
        input  pred_taken, pred_target
    );

    modport slave (
        input  lk_valid, lk_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
        output pred_taken, pred_target
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped predictor of tagged 2-bit saturating counters plus branch targets.
// Optional statistics counters are compiled in with `define BP_STATS_EN.
module branch_predictor #(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    branch_predictor_if.slave         bus
`ifdef BP_STATS_EN
    ,
    output logic [31:0]               stat_lookups,
    output logic [31:0]               stat_updates,
    output logic [31:0]               stat_mispred
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = bus.lk_pc[IDX_W+1:2];
    assign lk_tag = bus.lk_pc[PC_W-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        if (lk_hit && ctr_q[lk_idx][1]) begin
            bus.pred_taken  = 1'b1;
            bus.pred_target = target_q[lk_idx];
        end
    end

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_ctr_nxt;
    logic [PC_W-1:0]  upd_target_nxt;

    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = bus.upd_pc[PC_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // A miss replaces the entry outright; a not-taken hit keeps the old target.
    always_comb begin
        upd_ctr_nxt    = bus.upd_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        upd_target_nxt = bus.upd_target;
        if (upd_hit) begin
            upd_ctr_nxt = ctr_step(ctr_q[upd_idx], bus.upd_taken);
            if (!bus.upd_taken) upd_target_nxt = target_q[upd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
                target_q[i] <= '0;
            end
        end else if (bus.upd_valid) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            ctr_q[upd_idx]    <= upd_ctr_nxt;
            target_q[upd_idx] <= upd_target_nxt;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_updates <= '0;
            stat_mispred <= '0;
        end else begin
            if (bus.lk_valid && (stat_lookups != 32'hFFFF_FFFF))
                stat_lookups <= stat_lookups + 32'd1;
            if (bus.upd_valid && (stat_updates != 32'hFFFF_FFFF))
                stat_updates <= stat_updates + 32'd1;
            if (bus.upd_valid && bus.upd_mispred && (stat_mispred != 32'hFFFF_FFFF))
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`else
    logic unused_stat_inputs;
    assign unused_stat_inputs = bus.lk_valid ^ bus.upd_mispred;
`endif

    // Instructions are word aligned, so the byte-offset bits carry no information.
    logic unused_pc_offset;
    assign unused_pc_offset = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16: index = pc[5:2], tag = pc[31:6]).
// Statistics checks are included when BP_STATS_EN is defined.
module tb_branch_predictor;
    localparam int PC_W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    branch_predictor_if #(.PC_W(PC_W)) bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispred;
`endif

    branch_predictor #(.PC_W(PC_W), .ENTRIES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef BP_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_updates (stat_updates),
        .stat_mispred (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc);
        bus.lk_valid = 1'b1;
        bus.lk_pc    = pc;
        #1;
    endtask

    task automatic apply_stimulus(input logic [PC_W-1:0] pc, input logic taken,
                                  input logic [PC_W-1:0] target, input logic mispred);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = pc;
        bus.upd_taken   = taken;
        bus.upd_target  = target;
        bus.upd_mispred = mispred;
        tick();
        bus.upd_valid   = 1'b0;
        bus.upd_mispred = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic exp_taken,
                                input logic [PC_W-1:0] exp_target);
        total++;
        assert (bus.pred_taken === exp_taken) else begin
            bad++;
            $error("FAIL %s pred_taken: observed=%0b expected=%0b", tag, bus.pred_taken, exp_taken);
        end
        total++;
        assert (bus.pred_target === exp_target) else begin
            bad++;
            $error("FAIL %s pred_target: observed=%0h expected=%0h", tag, bus.pred_target, exp_target);
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.lk_valid    = 1'b0;
        bus.lk_pc       = '0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = '0;
        bus.upd_mispred = 1'b0;

        // Reset, then the table must be empty.
        tick();
        rst = 1'b0;
        lookup(32'h100);
        check_output("reset_0x100", 1'b0, 32'h0);
        lookup(32'h40);
        check_output("reset_0x40", 1'b0, 32'h0);

        // Allocate and train 0x100 (index 0, tag 4).
        apply_stimulus(32'h100, 1'b1, 32'h80, 1'b0);
        lookup(32'h100);
        check_output("alloc_taken", 1'b1, 32'h80);
        apply_stimulus(32'h100, 1'b1, 32'h84, 1'b0);
        lookup(32'h100);
        check_output("train_ctr11", 1'b1, 32'h84);
        apply_stimulus(32'h100, 1'b0, 32'hDEAD, 1'b1);
        lookup(32'h100);
        check_output("nt_keeps_target", 1'b1, 32'h84);
        apply_stimulus(32'h100, 1'b0, 32'hBEEF, 1'b1);
        lookup(32'h100);
        check_output("ctr01_not_taken", 1'b0, 32'h0);
        apply_stimulus(32'h100, 1'b1, 32'h88, 1'b1);
        lookup(32'h100);
        check_output("ctr01_to_10", 1'b1, 32'h88);

        // Saturation on 0x40 (index 0, tag 1), which also evicts 0x100.
        for (int i = 0; i < 5; i++) apply_stimulus(32'h40, 1'b1, 32'h200, 1'b0);
        lookup(32'h40);
        check_output("sat_taken", 1'b1, 32'h200);
        lookup(32'h100);
        check_output("evicted_by_0x40", 1'b0, 32'h0);
        apply_stimulus(32'h40, 1'b0, 32'h0, 1'b1);
        lookup(32'h40);
        check_output("sat_one_nt", 1'b1, 32'h200);
        apply_stimulus(32'h40, 1'b0, 32'h0, 1'b1);
        lookup(32'h40);
        check_output("sat_two_nt", 1'b0, 32'h0);

        // Alias eviction between 0x100 and 0x140 (both index 0).
        apply_stimulus(32'h100, 1'b1, 32'h300, 1'b0);
        apply_stimulus(32'h100, 1'b1, 32'h300, 1'b0);
        lookup(32'h100);
        check_output("alias_trained", 1'b1, 32'h300);
        apply_stimulus(32'h140, 1'b1, 32'h400, 1'b0);
        lookup(32'h140);
        check_output("alias_new_owner", 1'b1, 32'h400);
        lookup(32'h100);
        check_output("alias_old_miss", 1'b0, 32'h0);
        lookup(32'h143);
        check_output("offset_ignored", 1'b1, 32'h400);

        // A neighbouring index is independent.
        apply_stimulus(32'h104, 1'b0, 32'h500, 1'b0);
        lookup(32'h104);
        check_output("idx1_alloc_nt", 1'b0, 32'h0);
        apply_stimulus(32'h104, 1'b1, 32'h504, 1'b0);
        lookup(32'h104);
        check_output("idx1_taken", 1'b1, 32'h504);
        lookup(32'h140);
        check_output("idx0_untouched", 1'b1, 32'h400);

        // Same-cycle lookup and update: lookup sees the pre-update counter (10).
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h140;
        bus.upd_taken  = 1'b0;
        bus.upd_target = 32'h0;
        lookup(32'h140);
        check_output("same_cycle_pre", 1'b1, 32'h400);
        tick();
        bus.upd_valid = 1'b0;
        lookup(32'h140);
        check_output("same_cycle_post", 1'b0, 32'h0);

        // Reset wins over a simultaneous update and clears everything learned.
        rst            = 1'b1;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h180;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h600;
        tick();
        rst           = 1'b0;
        bus.upd_valid = 1'b0;
        lookup(32'h180);
        check_output("rst_vs_update", 1'b0, 32'h0);
        lookup(32'h104);
        check_output("rst_clears_idx1", 1'b0, 32'h0);
        apply_stimulus(32'h180, 1'b1, 32'h610, 1'b0);
        lookup(32'h180);
        check_output("after_rst_alloc", 1'b1, 32'h610);

`ifdef BP_STATS_EN
        bus.lk_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("stat_lookups_rst0", stat_lookups, 32'd0);
        check_value("stat_updates_rst0", stat_updates, 32'd0);
        check_value("stat_mispred_rst0", stat_mispred, 32'd0);
        for (int i = 0; i < 10; i++) begin
            bus.lk_valid    = 1'b1;
            bus.lk_pc       = 32'h100;
            bus.upd_valid   = (i < 4);
            bus.upd_pc      = 32'h100;
            bus.upd_taken   = 1'b1;
            bus.upd_target  = 32'h80;
            bus.upd_mispred = (i < 2);
            tick();
        end
        bus.lk_valid    = 1'b0;
        bus.upd_valid   = 1'b0;
        bus.upd_mispred = 1'b0;
        tick();
        check_value("stat_lookups", stat_lookups, 32'd10);
        check_value("stat_updates", stat_updates, 32'd4);
        check_value("stat_mispred", stat_mispred, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("stat_lookups_rst", stat_lookups, 32'd0);
        check_value("stat_updates_rst", stat_updates, 32'd0);
        check_value("stat_mispred_rst", stat_mispred, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
